// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline stage with req/ack data-memory access and register write-back
// Non-memory ops write back one cycle after acceptance; loads and stores hold the stage in ACCESS until mem_ack.

module mem_wb_stage #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned REG_AW      = 5,
  parameter bit          ZERO_REG_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_mem_to_reg,
  input  logic              ex_mem_write,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [31:0]       retired,
  output logic              protocol_err
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_load;
  logic                r_reg_write;
  logic [REG_AW-1:0]   r_rd;

  logic                w_accept;
  logic                w_is_mem;
  logic                w_ex_wb_ok;
  logic                w_mem_wb_ok;

  logic                w_mem_req_nxt;
  logic                w_mem_we_nxt;
  logic [ADDR_W-1:0]   w_mem_addr_nxt;
  logic [DATA_W-1:0]   w_mem_wdata_nxt;
  logic                w_wb_we_nxt;
  logic [REG_AW-1:0]   w_wb_addr_nxt;
  logic [DATA_W-1:0]   w_wb_data_nxt;
  logic [31:0]         w_retired_nxt;
  logic                w_perr_nxt;
  logic                w_load_nxt;
  logic                w_reg_write_nxt;
  logic [REG_AW-1:0]   w_rd_nxt;

  assign ex_ready    = (r_state == IDLE);
  assign w_accept    = ex_valid & ex_ready;
  assign w_is_mem    = ex_mem_to_reg | ex_mem_write;
  // Register 0 is hardwired when ZERO_REG_EN is set, so its writes are dropped.
  assign w_ex_wb_ok  = ex_reg_write & ~(ZERO_REG_EN && (ex_rd == '0));
  assign w_mem_wb_ok = r_load & r_reg_write & ~(ZERO_REG_EN && (r_rd == '0));

  always_comb begin
    w_state_nxt     = r_state;
    w_mem_req_nxt   = mem_req;
    w_mem_we_nxt    = mem_we;
    w_mem_addr_nxt  = mem_addr;
    w_mem_wdata_nxt = mem_wdata;
    w_wb_we_nxt     = 1'b0;
    w_wb_addr_nxt   = wb_addr;
    w_wb_data_nxt   = wb_data;
    w_retired_nxt   = retired;
    w_perr_nxt      = protocol_err | (mem_ack & (r_state == IDLE));
    w_load_nxt      = r_load;
    w_reg_write_nxt = r_reg_write;
    w_rd_nxt        = r_rd;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_is_mem) begin
            w_state_nxt     = ACCESS;
            w_mem_req_nxt   = 1'b1;
            w_mem_we_nxt    = ex_mem_write;
            w_mem_addr_nxt  = ex_alu_result[ADDR_W-1:0];
            w_mem_wdata_nxt = ex_store_data;
            // A store with mem_to_reg also set is still a store.
            w_load_nxt      = ex_mem_to_reg & ~ex_mem_write;
            w_reg_write_nxt = ex_reg_write;
            w_rd_nxt        = ex_rd;
          end else begin
            w_wb_we_nxt   = w_ex_wb_ok;
            w_retired_nxt = retired + 32'd1;
            if (w_ex_wb_ok) begin
              w_wb_addr_nxt = ex_rd;
              w_wb_data_nxt = ex_alu_result;
            end
          end
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          w_state_nxt   = IDLE;
          w_mem_req_nxt = 1'b0;
          w_retired_nxt = retired + 32'd1;
          w_wb_we_nxt   = w_mem_wb_ok;
          if (w_mem_wb_ok) begin
            w_wb_addr_nxt = r_rd;
            w_wb_data_nxt = mem_rdata;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      wb_we        <= 1'b0;
      wb_addr      <= '0;
      wb_data      <= '0;
      retired      <= '0;
      protocol_err <= 1'b0;
      r_load       <= 1'b0;
      r_reg_write  <= 1'b0;
      r_rd         <= '0;
    end else begin
      r_state      <= w_state_nxt;
      mem_req      <= w_mem_req_nxt;
      mem_we       <= w_mem_we_nxt;
      mem_addr     <= w_mem_addr_nxt;
      mem_wdata    <= w_mem_wdata_nxt;
      wb_we        <= w_wb_we_nxt;
      wb_addr      <= w_wb_addr_nxt;
      wb_data      <= w_wb_data_nxt;
      retired      <= w_retired_nxt;
      protocol_err <= w_perr_nxt;
      r_load       <= w_load_nxt;
      r_reg_write  <= w_reg_write_nxt;
      r_rd         <= w_rd_nxt;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage against a transaction-level model
// Inputs are driven and outputs sampled on the falling edge; the bench also plays the data memory.

module tb_mem_wb_stage;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              ex_valid;
  logic              ex_ready;
  logic              ex_mem_to_reg;
  logic              ex_mem_write;
  logic              ex_reg_write;
  logic [REG_AW-1:0] ex_rd;
  logic [DATA_W-1:0] ex_alu_result;
  logic [DATA_W-1:0] ex_store_data;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              wb_we;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [31:0]       retired;
  logic              protocol_err;

  mem_wb_stage #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_AW(REG_AW), .ZERO_REG_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .retired(retired), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned exp_retired = 0;
  bit          exp_perr = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic idle_cycle(input bit ack);
    ex_valid  = 1'b0;
    mem_ack   = ack;
    mem_rdata = $urandom;
    @(negedge clk);
    mem_ack = 1'b0;
    if (ack) exp_perr = 1'b1;
    check("idle_wb_we", wb_we, 0);
    check("idle_ready", ex_ready, 1);
    check("idle_req", mem_req, 0);
    check("idle_retired", retired, exp_retired);
    check("idle_perr", protocol_err, exp_perr);
  endtask

  // One instruction from acceptance to completion; returns on the first IDLE cycle afterwards.
  task automatic do_instr(input bit mtr, input bit mw, input bit rw, input logic [REG_AW-1:0] rd,
                          input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] sd,
                          input int lat, input logic [DATA_W-1:0] rdata, input bit junk);
    bit is_mem;
    bit is_load;
    bit exp_we;
    logic [ADDR_W-1:0] exp_addr;
    is_mem   = mtr | mw;
    is_load  = mtr & ~mw;
    exp_addr = alu[ADDR_W-1:0];
    check("pre_ready", ex_ready, 1);
    ex_valid      = 1'b1;
    ex_mem_to_reg = mtr;
    ex_mem_write  = mw;
    ex_reg_write  = rw;
    ex_rd         = rd;
    ex_alu_result = alu;
    ex_store_data = sd;
    mem_ack       = 1'b0;
    @(negedge clk);
    ex_valid = 1'b0;
    if (!is_mem) begin
      exp_we = rw && (rd != 0);
      exp_retired++;
      check("alu_wb_we", wb_we, exp_we);
      if (exp_we) begin
        check("alu_wb_addr", wb_addr, rd);
        check("alu_wb_data", wb_data, alu);
      end
      check("alu_ready", ex_ready, 1);
      check("alu_req", mem_req, 0);
      check("alu_retired", retired, exp_retired);
    end else begin
      for (int j = 1; j <= lat; j++) begin
        check("acc_req", mem_req, 1);
        check("acc_we", mem_we, mw);
        check("acc_addr", mem_addr, exp_addr);
        check("acc_wdata", mem_wdata, sd);
        check("acc_ready", ex_ready, 0);
        check("acc_wb_we", wb_we, 0);
        if (junk) begin
          ex_valid      = 1'b1;
          ex_mem_to_reg = 1'($urandom);
          ex_mem_write  = 1'($urandom);
          ex_reg_write  = 1'b1;
          ex_rd         = REG_AW'($urandom);
          ex_alu_result = $urandom;
          ex_store_data = $urandom;
        end
        if (j == lat) begin
          mem_ack   = 1'b1;
          mem_rdata = rdata;
        end
        @(negedge clk);
      end
      ex_valid  = 1'b0;
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      exp_we    = is_load && rw && (rd != 0);
      exp_retired++;
      check("done_req", mem_req, 0);
      check("done_ready", ex_ready, 1);
      check("done_wb_we", wb_we, exp_we);
      if (exp_we) begin
        check("done_wb_addr", wb_addr, rd);
        check("done_wb_data", wb_data, rdata);
      end
      check("done_retired", retired, exp_retired);
    end
    check("perr", protocol_err, exp_perr);
  endtask

  initial begin
    ex_valid = 0; ex_mem_to_reg = 0; ex_mem_write = 0; ex_reg_write = 0;
    ex_rd = '0; ex_alu_result = '0; ex_store_data = '0;
    mem_rdata = '0; mem_ack = 0;

    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_ready", ex_ready, 1);
    check("rst_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_wb_we", wb_we, 0);
    check("rst_wb_addr", wb_addr, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_retired", retired, 0);
    check("rst_perr", protocol_err, 0);
    idle_cycle(0);

    do_instr(0, 0, 1, 5'd3, 32'h0000_002A, 32'h0, 1, 32'h0, 0);
    idle_cycle(0);
    do_instr(1, 0, 1, 5'd7, 32'h0001_0010, $urandom, 3, 32'hDEAD_BEEF, 0);
    do_instr(0, 1, 0, 5'd9, 32'h0000_0004, 32'h1234_5678, 1, $urandom, 0);
    idle_cycle(0);

    do_instr(0, 0, 1, 5'd1, $urandom, $urandom, 1, 32'h0, 0);
    do_instr(1, 0, 1, 5'd2, $urandom, $urandom, 1, $urandom, 0);
    do_instr(0, 0, 1, 5'd3, $urandom, $urandom, 1, 32'h0, 0);
    do_instr(0, 0, 1, 5'd0, $urandom, $urandom, 1, 32'h0, 0);
    do_instr(1, 0, 1, 5'd0, $urandom, $urandom, 2, $urandom, 0);
    do_instr(1, 1, 1, 5'd5, $urandom, $urandom, 2, $urandom, 1);
    idle_cycle(0);

    for (int i = 0; i < 300; i++) begin
      int kind;
      logic [REG_AW-1:0] rd;
      kind = $urandom_range(0, 3);
      rd   = ($urandom_range(0, 7) == 0) ? '0 : REG_AW'($urandom);
      do_instr(kind == 1 || kind == 3, kind >= 2, 1'($urandom), rd, $urandom, $urandom,
               $urandom_range(1, 4), $urandom, 1'($urandom));
      if ($urandom_range(0, 2) == 0) idle_cycle($urandom_range(0, 15) == 0);
    end

    // Reset two cycles into a load's ACCESS: request drops at once, nothing writes back.
    ex_valid = 1; ex_mem_to_reg = 1; ex_mem_write = 0; ex_reg_write = 1;
    ex_rd = 5'd9; ex_alu_result = 32'h0000_0100; mem_ack = 0;
    @(negedge clk);
    ex_valid = 0;
    @(negedge clk);
    check("pre_rst_req", mem_req, 1);
    rst = 1'b1;
    #1;
    exp_retired = 0;
    exp_perr    = 1'b0;
    check("async_req", mem_req, 0);
    check("async_ready", ex_ready, 1);
    check("async_retired", retired, 0);
    @(negedge clk);
    rst = 1'b0;
    idle_cycle(0);
    idle_cycle(0);

    idle_cycle(1);
    check("perr_set", protocol_err, 1);
    do_instr(0, 0, 1, 5'd4, $urandom, $urandom, 1, 32'h0, 0);
    do_instr(1, 0, 1, 5'd6, $urandom, $urandom, 2, $urandom, 0);
    idle_cycle(0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
